// File: rtl/eleven_ctrl.sv
// Divisibility-by-11 checker with two round-robin requesters and a valid/ready response port.
// Each operand is scanned one 4-bit digit per cycle, digit 1 first, into an alternating-sum accumulator kept mod 11.
module eleven_ctrl #(
    parameter int n = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    input  logic [4*n-1:0] req0_a,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [4*n-1:0] req1_a,
    output logic           req1_ready,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic           resp_div,
    output logic [3:0]     resp_rem
);

    // state | meaning
    // IDLE  | waiting for an operand; ready follows the grant winner
    // RUN   | consuming one digit per cycle, then one terminal-count cycle
    // DONE  | result presented until the consumer takes it
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW = $clog2(n + 1);

    state_t         state_q, state_d;
    logic [4*n-1:0] sh_q, sh_d;
    logic [3:0]     acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           odd_q, odd_d;
    logic           id_q, id_d;
    logic           prio_q, prio_d;

    logic           any_v;
    logic           gnt_id;
    logic [3:0]     dig;
    logic [4:0]     add_s;
    logic signed [5:0] sub_s;
    logic [3:0]     acc_add;
    logic [3:0]     acc_sub;

    // prio_q names the requester that wins a tie
    assign any_v  = req0_valid | req1_valid;
    assign gnt_id = (req0_valid & req1_valid) ? prio_q : req1_valid;

    assign req0_ready = rst_n & (state_q == IDLE) & req0_valid & ~gnt_id;
    assign req1_ready = rst_n & (state_q == IDLE) & req1_valid & gnt_id;

    assign resp_valid = (state_q == DONE);
    assign resp_div   = (state_q == DONE) && (acc_q == 4'd0);
    assign resp_rem   = (state_q == DONE) ? acc_q : 4'd0;
    assign resp_id    = id_q;

    assign dig = sh_q[3:0];

    // acc+d reaches 25 and acc-d reaches -15, so at most two corrections are needed
    always_comb begin
        add_s   = {1'b0, acc_q} + {1'b0, dig};
        acc_add = add_s[3:0];
        if (add_s >= 5'd22)
            acc_add = 4'(add_s - 5'd22);
        else if (add_s >= 5'd11)
            acc_add = 4'(add_s - 5'd11);

        sub_s   = $signed({2'b00, acc_q}) - $signed({2'b00, dig});
        acc_sub = sub_s[3:0];
        if (sub_s < -6'sd11)
            acc_sub = 4'(sub_s + 6'sd22);
        else if (sub_s < 6'sd0)
            acc_sub = 4'(sub_s + 6'sd11);
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        odd_d   = odd_q;
        id_d    = id_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (any_v) begin
                    sh_d    = gnt_id ? req1_a : req0_a;
                    id_d    = gnt_id;
                    acc_d   = 4'd0;
                    cnt_d   = CW'(n);
                    odd_d   = 1'b1;
                    prio_d  = ~gnt_id;
                    state_d = RUN;
                end
            end
            RUN: begin
                // n digit cycles, then the cycle that sees the terminal count commits to DONE
                if (cnt_q != '0) begin
                    acc_d = odd_q ? acc_add : acc_sub;
                    sh_d  = sh_q >> 4;
                    odd_d = ~odd_q;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            acc_q   <= 4'd0;
            cnt_q   <= '0;
            odd_q   <= 1'b1;
            id_q    <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            odd_q   <= odd_d;
            id_q    <= id_d;
            prio_q  <= prio_d;
        end
    end

endmodule

// File: tb/tb_eleven_ctrl.sv
// Directed bench for eleven_ctrl (n=4): hand-computed remainders, round-robin order, stall and reset abort.
module tb_eleven_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [15:0] req0_a = '0, req1_a = '0;
    logic        req0_ready, req1_ready;
    logic        resp_valid, resp_id, resp_div;
    logic        resp_ready = 1'b0;
    logic [3:0]  resp_rem;

    int total = 0;
    int bad   = 0;

    eleven_ctrl #(.n(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_ready (req1_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_div   (resp_div),
        .resp_rem   (resp_rem)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (resp_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
    endtask

    // one operand from idle: grant check, acceptance, inputs scrambled during RUN, latency and fields
    task automatic run_op(input string tag, input logic v0, input logic v1,
                          input logic [15:0] a0, input logic [15:0] a1,
                          input logic e_id, input logic [3:0] e_rem, input logic e_div);
        int k;
        req0_valid = v0; req1_valid = v1; req0_a = a0; req1_a = a1;
        #1;
        chk({tag, ".rdy0"}, req0_ready, v0 && !e_id);
        chk({tag, ".rdy1"}, req1_ready, v1 && e_id);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 16'h5A5A; req1_a = 16'hA5A5;
        wait_valid(k);
        chk({tag, ".lat"}, k, 5);
        chk({tag, ".id"},  resp_id,  e_id);
        chk({tag, ".rem"}, resp_rem, e_rem);
        chk({tag, ".div"}, resp_div, e_div);
        chk({tag, ".busy_rdy"}, {req0_ready, req1_ready}, 2'b00);
        resp_ready = 1'b1;
        tick();
        chk({tag, ".vld_fall"}, resp_valid, 1'b0);
        resp_ready = 1'b0;
    endtask

    initial begin
        int k;
        int seen;

        // reset with both requesters asking
        req0_valid = 1'b1; req1_valid = 1'b1; req0_a = 16'h1234; req1_a = 16'h4321;
        #2;
        chk("rst.rdy", {req0_ready, req1_ready}, 2'b00);
        chk("rst.vld", resp_valid, 1'b0);
        chk("rst.id",  resp_id,    1'b0);
        chk("rst.div", resp_div,   1'b0);
        chk("rst.rem", resp_rem,   4'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // 0-1+2-1=0 ; 2-1=1 ; 9-9+9-9=0 ; 0-15 -> 7
        run_op("v1210", 1, 0, 16'h1210, 16'h0000, 1'b0, 4'd0, 1'b1);
        run_op("v0012", 0, 1, 16'h0000, 16'h0012, 1'b1, 4'd1, 1'b0);
        run_op("v9999", 0, 1, 16'h0000, 16'h9999, 1'b1, 4'd0, 1'b1);
        run_op("v00F0", 1, 0, 16'h00F0, 16'h0000, 1'b0, 4'd7, 1'b0);
        // tie with pointer on 1: 10+10=20 -> 9
        run_op("v0A0A", 1, 1, 16'h000F, 16'h0A0A, 1'b1, 4'd9, 1'b0);
        // tie with pointer on 0: 15-15+15-15 passes through exactly -11
        run_op("vFFFF", 1, 1, 16'hFFFF, 16'h1234, 1'b0, 4'd0, 1'b1);
        // 15 -> 4
        run_op("v000F", 0, 1, 16'h0000, 16'h000F, 1'b1, 4'd4, 1'b0);

        // both held valid, consumer always ready: ids 0,1,0,1, DONE one cycle
        req0_valid = 1'b1; req1_valid = 1'b1; req0_a = 16'h1210; req1_a = 16'h0012;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid(k);
            chk("rr.lat", k, 6);
            chk("rr.id",  resp_id,  i[0]);
            chk("rr.rem", resp_rem, i[0] ? 4'd1 : 4'd0);
            if (i == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            tick();
            chk("rr.done1", resp_valid, 1'b0);
        end
        resp_ready = 1'b0;

        // stall in DONE for 10 cycles while both requesters push new operands
        req0_valid = 1'b1; req0_a = 16'h0012;
        #1;
        chk("st.rdy0", req0_ready, 1'b1);
        tick();
        req1_valid = 1'b1; req0_a = 16'h00F0; req1_a = 16'h9999;
        wait_valid(k);
        chk("st.lat", k, 5);
        for (int c = 0; c < 10; c++) begin
            chk("st.fields", {resp_valid, resp_id, resp_div, resp_rem}, {1'b1, 1'b0, 1'b0, 4'd1});
            chk("st.rdy", {req0_ready, req1_ready}, 2'b00);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        chk("st.vld_fall", resp_valid, 1'b0);
        resp_ready = 1'b0;

        // reset in the second RUN cycle; pointer was moved to 1 by this acceptance
        req0_valid = 1'b1; req0_a = 16'h1210;
        tick();
        req0_valid = 1'b0;
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("ab.rdy", {req0_ready, req1_ready}, 2'b00);
        chk("ab.out", {resp_valid, resp_id, resp_div, resp_rem}, 7'd0);
        tick();
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (resp_valid === 1'b1) seen++;
        end
        chk("ab.no_resp", seen, 0);
        run_op("ab.next", 1, 1, 16'h9999, 16'h0012, 1'b0, 4'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
